// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word fall-through reads; default is a registered read.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DATA_DEPTH    = 128,
  parameter int unsigned AFULL_THRESH  = DATA_DEPTH - 4,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        wr_en,
  input  logic                        rd_en,
  input  logic                        clr_err,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [$clog2(DATA_DEPTH):0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int unsigned AW = $clog2(DATA_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          rd_acc, wr_acc;

  always_comb begin
    rd_acc   = rd_en & ~empty_q;
    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    wr_acc   = wr_en & (~full_q | rd_acc);
    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d   = (count_d == CW'(DATA_DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CW'(AFULL_THRESH));
    aempty_d = (count_d <= CW'(AEMPTY_THRESH));
    // A new error event wins over a simultaneous clear.
    ovf_d    = (wr_en & ~wr_acc) | (ovf_q & ~clr_err);
    unf_d    = (rd_en & ~rd_acc) | (unf_q & ~clr_err);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_acc && !Reset) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head entry is driven straight from storage; only registered state feeds it.
  assign data_out = empty_q ? '0 : mem_q[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      dout_q <= '0;
    end else if (rd_acc) begin
      dout_q <= mem_q[rd_ptr_q];
    end
  end

  assign data_out = dout_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo with a queue scoreboard and a small occupancy/flag model.
module tb_sync_fifo;

  localparam int DEPTH = 128;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] data_in = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [7:0] count;

  sync_fifo dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .data_in      (data_in),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .clr_err      (clr_err),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 Clk = ~Clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  int         m_count = 0;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic [7:0] m_dout_reg = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] m_dout;
`ifdef FIFO_FWFT_EN
    m_dout = (m_count == 0) ? 8'h00 : exp_q[0];
`else
    m_dout = m_dout_reg;
`endif
    chk({tag, ".count"}, 32'(count), 32'(m_count));
    chk({tag, ".empty"}, 32'(empty), 32'(m_count == 0));
    chk({tag, ".full"}, 32'(full), 32'(m_count == DEPTH));
    chk({tag, ".afull"}, 32'(almost_full), 32'(m_count >= DEPTH - 4));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(m_count <= 4));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    chk({tag, ".dout"}, 32'(data_out), 32'(m_dout));
  endtask

  task automatic step(input string tag, input logic w, input logic r, input logic c,
                      input logic [7:0] d);
    bit rd_ok, wr_ok;
    rd_ok = r && (m_count != 0);
    wr_ok = w && ((m_count < DEPTH) || rd_ok);
    wr_en = w; rd_en = r; clr_err = c; data_in = d;
    @(posedge Clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    if (rd_ok) m_dout_reg = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(d);
    m_count = exp_q.size();
    m_ovf = (m_ovf && !c) || (w && !wr_ok);
    m_unf = (m_unf && !c) || (r && !rd_ok);
    check_all(tag);
  endtask

  // Reset asserted together with every request to prove it overrides them.
  task automatic do_reset(input string tag);
    Reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1; clr_err = 1'b1; data_in = 8'hEE;
    @(posedge Clk); #1;
    Reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    exp_q.delete();
    m_count = 0; m_ovf = 1'b0; m_unf = 1'b0; m_dout_reg = '0;
    check_all(tag);
  endtask

  initial begin
    @(posedge Clk); #1;
    do_reset("reset");

    // Underflow and clear behaviour.
    step("unf_rd", 1'b0, 1'b1, 1'b0, 8'h00);
    chk("unf_set", 32'(underflow), 32'd1);
    step("unf_clr", 1'b0, 1'b0, 1'b1, 8'h00);
    chk("unf_cleared", 32'(underflow), 32'd0);
    step("unf_rd2", 1'b0, 1'b1, 1'b0, 8'h00);
    step("unf_clr_rd", 1'b0, 1'b1, 1'b1, 8'h00);
    chk("unf_set_wins", 32'(underflow), 32'd1);
    step("unf_clr2", 1'b0, 1'b0, 1'b1, 8'h00);

    // Fill 0..127.
    for (int i = 0; i < DEPTH; i++) begin
      step("fill", 1'b1, 1'b0, 1'b0, 8'(i));
      if (i == 4) chk("fill_aempty_at5", 32'(almost_empty), 32'd0);
      if (i == 123) chk("fill_afull_at124", 32'(almost_full), 32'd1);
      if (i == 122) chk("fill_afull_at123", 32'(almost_full), 32'd0);
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd128);

    // Overflow then full simultaneous read/write.
    step("ovf_wr", 1'b1, 1'b0, 1'b0, 8'd200);
    chk("ovf_set", 32'(overflow), 32'd1);
    step("full_rw", 1'b1, 1'b1, 1'b0, 8'd255);
    chk("full_rw_full", 32'(full), 32'd1);
    chk("full_rw_count", 32'(count), 32'd128);

    // Drain; scoreboard checks order and that 255 comes last.
    while (m_count > 0) step("drain", 1'b0, 1'b1, 1'b0, 8'h00);
    chk("drain_empty", 32'(empty), 32'd1);
    step("clr_ovf", 1'b0, 1'b0, 1'b1, 8'h00);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Write into empty with simultaneous read: write lands, read rejected.
    step("wr_rd_empty", 1'b1, 1'b1, 1'b0, 8'h5A);
    chk("wr_rd_empty_unf", 32'(underflow), 32'd1);
    chk("wr_rd_empty_cnt", 32'(count), 32'd1);
    step("fwft_read", 1'b0, 1'b1, 1'b1, 8'h00);

    // Stream across pointer wrap with low occupancy.
    for (int i = 0; i < 300; i++) begin
      if (m_count >= 3) step("stream_rw", 1'b1, 1'b1, 1'b0, i[7:0]);
      else step("stream_w", 1'b1, 1'b0, 1'b0, i[7:0]);
    end
    while (m_count > 0) step("stream_drain", 1'b0, 1'b1, 1'b0, 8'h00);

    // Mid-stream reset with 50 words stored.
    for (int i = 0; i < 50; i++) step("pre_rst", 1'b1, 1'b0, 1'b0, 8'(i + 7));
    do_reset("mid_reset");
    chk("mid_reset_count", 32'(count), 32'd0);
    step("post_rst_wr", 1'b1, 1'b0, 1'b0, 8'hC3);
    step("post_rst_rd", 1'b0, 1'b1, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
